// File: rtl/id_ex.sv
// id_ex: decode -> execute pipeline register for the RV32I five-stage core.
//   Captures the decoded bundle each cycle and holds it while stall_i is high.
//   Flush squashes the bundle to a NOP bubble. A load in this stage whose rd
//   matches a source that decode is reading forces a single bubble, and hold_o
//   asks the front end to freeze for that cycle.
//   Two saturating counters track inserted load-use bubbles and taken flushes.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   *_i bundle        : inst/inst_addr/op1/op2/mem_data (32), rd_addr (5),
//                       reg_wen/mem_we/mem_re (1), mem_size (3)
//   rs1/rs2_addr_i    : sources decode is reading now (0 when unused)
//   stall_i, flush_i  : downstream busy / branch-jump redirect
//   *_o bundle        : registered bundle to execute, valid_o
//   hold_o            : freeze PC and if_id (stall_i | load_use)
//   bubble_cnt_o, flush_cnt_o : saturating event counters
module id_ex #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst_i,
  input  logic [31:0]      inst_addr_i,
  input  logic [31:0]      op1_i,
  input  logic [31:0]      op2_i,
  input  logic [31:0]      mem_data_i,
  input  logic [4:0]       rd_addr_i,
  input  logic             reg_wen_i,
  input  logic             mem_we_i,
  input  logic             mem_re_i,
  input  logic [2:0]       mem_size_i,
  input  logic [4:0]       rs1_addr_i,
  input  logic [4:0]       rs2_addr_i,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic [31:0]      inst_o,
  output logic [31:0]      inst_addr_o,
  output logic [31:0]      op1_o,
  output logic [31:0]      op2_o,
  output logic [31:0]      mem_data_o,
  output logic [4:0]       rd_addr_o,
  output logic             reg_wen_o,
  output logic             mem_we_o,
  output logic             mem_re_o,
  output logic [2:0]       mem_size_o,
  output logic             valid_o,
  output logic             hold_o,
  output logic [CNT_W-1:0] bubble_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] mem_data;
    logic [4:0]  rd;
    logic        reg_wen;
    logic        mem_we;
    logic        mem_re;
    logic [2:0]  mem_size;
  } bundle_t;

  localparam bundle_t RST_B = '{inst: NOP_INST, default: '0};

  bundle_t          bnd_q, bnd_d, in_b;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] bub_q, bub_d, fl_q, fl_d;
  logic             load_use;

  assign in_b = '{inst: inst_i, addr: inst_addr_i, op1: op1_i, op2: op2_i,
                  mem_data: mem_data_i, rd: rd_addr_i, reg_wen: reg_wen_i,
                  mem_we: mem_we_i, mem_re: mem_re_i, mem_size: mem_size_i};

  // Only registered state and decode's source addresses feed this; a flush
  // masks it so a squashed load never costs an extra bubble.
  assign load_use = valid_q & bnd_q.mem_re & (bnd_q.rd != 5'd0) &
                    ((bnd_q.rd == rs1_addr_i) | (bnd_q.rd == rs2_addr_i)) & ~flush_i;
  assign hold_o   = stall_i | load_use;

  always_comb begin
    bnd_d   = bnd_q;
    valid_d = valid_q;
    bub_d   = bub_q;
    fl_d    = fl_q;
    if (flush_i) begin
      bnd_d      = RST_B;
      bnd_d.addr = inst_addr_i;
      valid_d    = 1'b0;
      if (fl_q != '1) fl_d = fl_q + CNT_W'(1);
    end else if (stall_i) begin
      // hold everything
    end else if (load_use) begin
      bnd_d      = RST_B;
      bnd_d.addr = inst_addr_i;
      valid_d    = 1'b0;
      if (bub_q != '1) bub_d = bub_q + CNT_W'(1);
    end else begin
      bnd_d   = in_b;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bnd_q   <= RST_B;
      valid_q <= 1'b0;
      bub_q   <= '0;
      fl_q    <= '0;
    end else begin
      bnd_q   <= bnd_d;
      valid_q <= valid_d;
      bub_q   <= bub_d;
      fl_q    <= fl_d;
    end
  end

  assign inst_o       = bnd_q.inst;
  assign inst_addr_o  = bnd_q.addr;
  assign op1_o        = bnd_q.op1;
  assign op2_o        = bnd_q.op2;
  assign mem_data_o   = bnd_q.mem_data;
  assign rd_addr_o    = bnd_q.rd;
  assign reg_wen_o    = bnd_q.reg_wen;
  assign mem_we_o     = bnd_q.mem_we;
  assign mem_re_o     = bnd_q.mem_re;
  assign mem_size_o   = bnd_q.mem_size;
  assign valid_o      = valid_q;
  assign bubble_cnt_o = bub_q;
  assign flush_cnt_o  = fl_q;

endmodule

// File: tb/tb_id_ex.sv
module tb_id_ex;
  localparam int CNT_W = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] inst_i, inst_addr_i, op1_i, op2_i, mem_data_i;
  logic [4:0]  rd_addr_i, rs1_addr_i, rs2_addr_i;
  logic        reg_wen_i, mem_we_i, mem_re_i, stall_i, flush_i;
  logic [2:0]  mem_size_i;
  logic [31:0] inst_o, inst_addr_o, op1_o, op2_o, mem_data_o;
  logic [4:0]  rd_addr_o;
  logic        reg_wen_o, mem_we_o, mem_re_o, valid_o, hold_o;
  logic [2:0]  mem_size_o;
  logic [CNT_W-1:0] bubble_cnt_o, flush_cnt_o;

  always #5 clk = ~clk;

  id_ex #(.NOP_INST(NOP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i), .op1_i(op1_i), .op2_i(op2_i),
    .mem_data_i(mem_data_i), .rd_addr_i(rd_addr_i), .reg_wen_i(reg_wen_i),
    .mem_we_i(mem_we_i), .mem_re_i(mem_re_i), .mem_size_i(mem_size_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .op1_o(op1_o), .op2_o(op2_o),
    .mem_data_o(mem_data_o), .rd_addr_o(rd_addr_o), .reg_wen_o(reg_wen_o),
    .mem_we_o(mem_we_o), .mem_re_o(mem_re_o), .mem_size_o(mem_size_o),
    .valid_o(valid_o), .hold_o(hold_o),
    .bubble_cnt_o(bubble_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] inst, addr, op1, op2, md;
    logic [4:0]  rd;
    logic        wen, we, re;
    logic [2:0]  sz;
  } bnd_t;

  bnd_t m;
  logic mv;
  int   nb, nf;   // raw event counts, saturated only when compared

  function automatic bnd_t bubble(input logic [31:0] a);
    bnd_t b;
    b = '{inst: NOP, addr: a, op1: 0, op2: 0, md: 0, rd: 0, wen: 0, we: 0, re: 0, sz: 0};
    return b;
  endfunction

  function automatic logic m_lu();
    return mv && m.re && m.rd != 0 && (m.rd == rs1_addr_i || m.rd == rs2_addr_i) && !flush_i;
  endfunction

  function automatic logic [CNT_W-1:0] sat(input int n);
    return (n >= (1 << CNT_W) - 1) ? {CNT_W{1'b1}} : CNT_W'(n);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m <= bubble(32'h0); mv <= 1'b0; nb <= 0; nf <= 0;
    end else if (flush_i) begin
      m <= bubble(inst_addr_i); mv <= 1'b0; nf <= nf + 1;
    end else if (stall_i) begin
      mv <= mv;
    end else if (m_lu()) begin
      m <= bubble(inst_addr_i); mv <= 1'b0; nb <= nb + 1;
    end else begin
      m <= '{inst: inst_i, addr: inst_addr_i, op1: op1_i, op2: op2_i, md: mem_data_i,
             rd: rd_addr_i, wen: reg_wen_i, we: mem_we_i, re: mem_re_i, sz: mem_size_i};
      mv <= 1'b1;
    end
  end

  // ---------------- checking ----------------
  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("inst_o", inst_o, m.inst);
    chk("inst_addr_o", inst_addr_o, m.addr);
    chk("op1_o", op1_o, m.op1);
    chk("op2_o", op2_o, m.op2);
    chk("mem_data_o", mem_data_o, m.md);
    chk("rd_addr_o", rd_addr_o, m.rd);
    chk("reg_wen_o", reg_wen_o, m.wen);
    chk("mem_we_o", mem_we_o, m.we);
    chk("mem_re_o", mem_re_o, m.re);
    chk("mem_size_o", mem_size_o, m.sz);
    chk("valid_o", valid_o, mv);
    chk("hold_o", hold_o, stall_i | (rst_n & m_lu()));
    chk("bubble_cnt_o", bubble_cnt_o, sat(nb));
    chk("flush_cnt_o", flush_cnt_o, sat(nf));
  endtask

  // inputs change at posedge+1; compare at negedge; return at posedge+1
  task automatic cyc();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [31:0] inst, input logic [4:0] rd, input logic wen,
                        input logic re, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] o1, input logic [31:0] o2);
    inst_i = inst; rd_addr_i = rd; reg_wen_i = wen; mem_re_i = re; mem_we_i = 1'b0;
    rs1_addr_i = rs1; rs2_addr_i = rs2; op1_i = o1; op2_i = o2;
    mem_data_i = 32'h0; mem_size_i = re ? 3'b010 : 3'b000;
    inst_addr_i = inst_addr_i + 32'd4;
  endtask

  task automatic rand_in();
    inst_i = $urandom; inst_addr_i = $urandom; op1_i = $urandom; op2_i = $urandom;
    mem_data_i = $urandom; rd_addr_i = 5'($urandom_range(0, 3));
    reg_wen_i = 1'($urandom); mem_we_i = 1'($urandom); mem_re_i = ($urandom_range(0, 1) == 0);
    mem_size_i = 3'($urandom); rs1_addr_i = 5'($urandom_range(0, 3));
    rs2_addr_i = 5'($urandom_range(0, 3));
    stall_i = ($urandom_range(0, 3) == 0); flush_i = ($urandom_range(0, 7) == 0);
  endtask

  localparam logic [31:0] ADDI = 32'h0070_8293, LW6 = 32'h0001_2303,
                          ADD7 = 32'h0013_03B3, LW0 = 32'h0001_2003, K = 32'h00A0_0513;

  initial begin
    inst_i = 0; inst_addr_i = 32'h1000; op1_i = 0; op2_i = 0; mem_data_i = 0;
    rd_addr_i = 0; reg_wen_i = 0; mem_we_i = 0; mem_re_i = 0; mem_size_i = 0;
    rs1_addr_i = 0; rs2_addr_i = 0; stall_i = 0; flush_i = 0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst inst_o", inst_o, NOP);
    chk("rst valid_o", valid_o, 1'b0);
    chk("rst bubble_cnt", bubble_cnt_o, 0);
    chk("rst flush_cnt", flush_cnt_o, 0);
    chk("rst hold_o", hold_o, 1'b0);
    rst_n = 1'b1;

    // pass-through: addi x5,x1,7
    set_in(ADDI, 5'd5, 1'b1, 1'b0, 5'd1, 5'd0, 32'h10, 32'd7);
    cyc();
    chk("pass inst_o", inst_o, ADDI);
    chk("pass op2_o", op2_o, 32'd7);
    chk("pass rd_addr_o", rd_addr_o, 5'd5);
    chk("pass valid_o", valid_o, 1'b1);
    chk("pass hold_o", hold_o, 1'b0);

    // load-use: lw x6,0(x2) then add x7,x6,x1
    set_in(LW6, 5'd6, 1'b1, 1'b1, 5'd2, 5'd0, 32'h200, 32'h0);
    cyc();
    set_in(ADD7, 5'd7, 1'b1, 1'b0, 5'd6, 5'd1, 32'h5, 32'h6);
    #1;
    chk("lu hold_o", hold_o, 1'b1);
    cyc();
    chk("lu bubble inst_o", inst_o, NOP);
    chk("lu bubble valid_o", valid_o, 1'b0);
    chk("lu bubble_cnt", bubble_cnt_o, 1);
    chk("lu hold released", hold_o, 1'b0);
    cyc();
    chk("lu held add inst_o", inst_o, ADD7);
    chk("lu held add valid_o", valid_o, 1'b1);

    // x0 load does not trigger a bubble
    set_in(LW0, 5'd0, 1'b1, 1'b1, 5'd2, 5'd0, 32'h200, 32'h0);
    cyc();
    set_in(K, 5'd10, 1'b1, 1'b0, 5'd0, 5'd0, 32'h0, 32'd10);
    #1;
    chk("x0 hold_o", hold_o, 1'b0);
    cyc();
    chk("x0 inst_o", inst_o, K);
    chk("x0 valid_o", valid_o, 1'b1);
    chk("x0 bubble_cnt", bubble_cnt_o, 1);

    // stall freezes, then flush overrides stall
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inst_i = $urandom; op2_i = $urandom;
      cyc();
      chk("stall inst_o", inst_o, K);
      chk("stall op2_o", op2_o, 32'd10);
    end
    flush_i = 1'b1;
    cyc();
    chk("flush inst_o", inst_o, NOP);
    chk("flush valid_o", valid_o, 1'b0);
    chk("flush flush_cnt", flush_cnt_o, 1);
    chk("flush bubble_cnt", bubble_cnt_o, 1);
    stall_i = 1'b0; flush_i = 1'b0;

    // randomized traffic with an asynchronous reset in the middle
    for (int i = 0; i < 3000; i++) begin
      rand_in();
      if (i == 1500) begin
        stall_i = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        chk("async rst inst_o", inst_o, NOP);
        chk("async rst valid_o", valid_o, 1'b0);
        chk("async rst bubble_cnt", bubble_cnt_o, 0);
        chk("async rst flush_cnt", flush_cnt_o, 0);
        chk("async rst hold_o", hold_o, 1'b1);
        cyc();
        rst_n = 1'b1;
      end else begin
        cyc();
      end
    end

    // flush counter saturation
    flush_i = 1'b1;
    for (int i = 0; i < (1 << CNT_W) + 2; i++) begin
      stall_i = 1'($urandom);
      rs1_addr_i = 5'($urandom_range(0, 3));
      cyc();
    end
    chk("sat flush_cnt", flush_cnt_o, 16'hFFFF);
    cyc();
    chk("sat flush_cnt stays", flush_cnt_o, 16'hFFFF);
    flush_i = 1'b0; stall_i = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
